// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - 3-stage pipelined round-to-nearest-even floating-point multiplier
// Defining FMUL_EXC_CNT_EN adds saturating ovf_cnt/udf_cnt exception counters.
module fmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   ovf,
  output logic                   udf
`ifdef FMUL_EXC_CNT_EN
  ,
  output logic [15:0]            ovf_cnt,
  output logic [15:0]            udf_cnt
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic load2, load3;
  logic v1, v2, v3;

  assign load3     = !v3 || out_ready;
  assign load2     = !v2 || load3;
  assign in_ready  = !v1 || load2;
  assign out_valid = v3;

  // Stage 1: unpack, classify, exponent sum and full mantissa product
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [EW-1:0] exp_sum;
  logic [PW-1:0]        prod;

  assign {a_s, a_e, a_m} = x1;
  assign {b_s, b_e, b_m} = x2;
  assign a_zero  = (a_e == '0);
  assign b_zero  = (b_e == '0);
  assign a_inf   = (a_e == EXP_ONES) && (a_m == '0);
  assign b_inf   = (b_e == EXP_ONES) && (b_m == '0);
  assign a_nan   = (a_e == EXP_ONES) && (a_m != '0);
  assign b_nan   = (b_e == EXP_ONES) && (b_m != '0);
  assign exp_sum = $signed({2'b00, a_e}) + $signed({2'b00, b_e}) - BIAS;
  assign prod    = PW'({1'b1, a_m}) * PW'({1'b1, b_m});

  logic                 s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [EW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_nan  <= 1'b0;
      s1_inf  <= 1'b0;
      s1_zero <= 1'b0;
      s1_exp  <= '0;
      s1_prod <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign <= a_s ^ b_s;
        s1_nan  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        s1_inf  <= a_inf || b_inf;
        s1_zero <= a_zero || b_zero;
        s1_exp  <= exp_sum;
        s1_prod <= prod;
      end
    end
  end

  // Stage 2: normalise to a leading one, then round to nearest even
  logic [PW-1:0]        norm;
  logic signed [EW-1:0] exp_n, exp_r;
  logic [MAN_W:0]       mant;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     man_r;
  logic                 guard, rnd, sticky, inc;

  always_comb begin
    norm   = s1_prod[PW-1] ? s1_prod : {s1_prod[PW-2:0], 1'b0};
    exp_n  = s1_prod[PW-1] ? s1_exp + EXP_ONE : s1_exp;
    mant   = norm[PW-1:MAN_W+1];
    guard  = norm[MAN_W];
    rnd    = norm[MAN_W-1];
    sticky = |norm[MAN_W-2:0];
    inc    = guard && (rnd || sticky || mant[0]);
    mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    if (mant_r[MAN_W+1]) begin
      exp_r = exp_n + EXP_ONE;
      man_r = mant_r[MAN_W:1];
    end else begin
      exp_r = exp_n;
      man_r = mant_r[MAN_W-1:0];
    end
  end

  logic                 s2_sign, s2_nan, s2_inf, s2_zero;
  logic signed [EW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_man;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_nan  <= 1'b0;
      s2_inf  <= 1'b0;
      s2_zero <= 1'b0;
      s2_exp  <= '0;
      s2_man  <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign <= s1_sign;
        s2_nan  <= s1_nan;
        s2_inf  <= s1_inf;
        s2_zero <= s1_zero;
        s2_exp  <= exp_r;
        s2_man  <= man_r;
      end
    end
  end

  // Stage 3: special-case priority and packing; results below the normal range flush to zero
  logic [W-1:0] y_n;
  logic         ovf_n, udf_n;

  always_comb begin
    y_n   = {s2_sign, s2_exp[EXP_W-1:0], s2_man};
    ovf_n = 1'b0;
    udf_n = 1'b0;
    if (s2_nan) begin
      y_n = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s2_inf) begin
      y_n = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s2_zero) begin
      y_n = {s2_sign, {(W-1){1'b0}}};
    end else if (s2_exp >= EXP_MAX) begin
      y_n   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else if (s2_exp <= EXP_ZERO) begin
      y_n   = {s2_sign, {(W-1){1'b0}}};
      udf_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v3  <= 1'b0;
      y   <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        y   <= y_n;
        ovf <= ovf_n;
        udf <= udf_n;
      end
    end
  end

`ifdef FMUL_EXC_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (ovf && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
      if (udf && (udf_cnt != 16'hFFFF)) udf_cnt <= udf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fmul_pipe.sv
// tb/tb_fmul_pipe.sv - self-checking bench for fmul_pipe against an integer RNE reference model
module tb_fmul_pipe;
  localparam int EW   = 8;
  localparam int MW   = 23;
  localparam int W    = 1 + EW + MW;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic         clk = 1'b0;
  logic         rstn, in_valid, in_ready, out_valid, out_ready, ovf, udf;
  logic [W-1:0] x1, x2, y;
`ifdef FMUL_EXC_CNT_EN
  logic [15:0]  ovf_cnt, udf_cnt;
`endif

  always #5 clk = ~clk;

  fmul_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .udf(udf)
`ifdef FMUL_EXC_CNT_EN
    , .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
  );

  int           n_cmp = 0;
  int           n_fail = 0;
  int           exp_ovf_n = 0;
  int           exp_udf_n = 0;
  bit           accepted;
  logic [W+1:0] scb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Exact integer product, rounded by comparing the discarded remainder with half an ulp
  function automatic logic [W+1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic s;
    int ea, eb, e, k;
    longint unsigned ma, mb, p, q, rem, half;
    bit za, zb, ia, ib, na, nb;
    s  = a[W-1] ^ b[W-1];
    ea = int'(a[W-2:MW]);
    eb = int'(b[W-2:MW]);
    ma = longint'(a[MW-1:0]);
    mb = longint'(b[MW-1:0]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == EMAX) && (ma == 0);
    ib = (eb == EMAX) && (mb == 0);
    na = (ea == EMAX) && (ma != 0);
    nb = (eb == EMAX) && (mb != 0);
    if (na || nb || (ia && zb) || (ib && za)) return {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}, 2'b00};
    if (ia || ib) return {s, {EW{1'b1}}, {MW{1'b0}}, 2'b00};
    if (za || zb) return {s, {(W-1){1'b0}}, 2'b00};
    p    = (ma + (64'd1 << MW)) * (mb + (64'd1 << MW));
    k    = (p >= (64'd1 << (2 * MW + 1))) ? MW + 1 : MW;
    q    = p >> k;
    rem  = p - (q << k);
    half = 64'd1 << (k - 1);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    e = ea + eb - BIAS + (k - MW);
    if (q == (64'd1 << (MW + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= EMAX) return {s, {EW{1'b1}}, {MW{1'b0}}, 2'b10};
    if (e <= 0) return {s, {(W-1){1'b0}}, 2'b01};
    return {s, e[EW-1:0], q[MW-1:0], 2'b00};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    r = W'($urandom);
    case ($urandom_range(0, 9))
      0: r[W-2:MW] = '0;
      1: begin
        r[W-2:MW] = '1;
        if ($urandom_range(0, 1) == 1) r[MW-1:0] = '0;
      end
      default: r[W-2:MW] = EW'($urandom_range(BIAS - 70, BIAS + 70));
    endcase
    return r;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy, input bit dir, input logic [W+1:0] dexp);
    logic [W+1:0] e;
    @(negedge clk);
    in_valid  = v;
    x1        = a;
    x2        = b;
    out_ready = ordy;
    #1;
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      if (scb.size() == 0) begin
        chk("extra_output", 64'(out_valid), 64'd0);
      end else begin
        e = scb.pop_front();
        chk("y", 64'(y), 64'(e[W+1:2]));
        chk("ovf", 64'(ovf), 64'(e[1]));
        chk("udf", 64'(udf), 64'(e[0]));
        exp_ovf_n += int'(e[1]);
        exp_udf_n += int'(e[0]);
      end
    end
    if (in_valid && in_ready) begin
      scb.push_back(dir ? dexp : ref_mul(a, b));
      accepted = 1'b1;
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit dir, input logic [W+1:0] dexp);
    int tries;
    tries = 0;
    do begin
      step(1'b1, a, b, 1'b1, dir, dexp);
      tries++;
    end while (!accepted && tries < 50);
    chk("send_accepted", 64'(accepted), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && scb.size() != 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0, '0);
    chk("drain_empty", 64'(scb.size()), 64'd0);
  endtask

  logic [W-1:0] bp_a[5];
  logic [W-1:0] bp_b[5];
  logic [W+1:0] bp_e[5];
  logic [W-1:0] y_hold;
  bit           was_stall;
  int           fed, idx;

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x1        = '0;
    x2        = '0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_udf", 64'(udf), 64'd0);
    rstn = 1'b1;
    step(1'b0, '0, '0, 1'b1, 1'b0, '0);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // latency: result appears exactly three cycles after acceptance
    send(32'h3FC00000, 32'h40000000, 1'b1, {32'h40400000, 2'b00});
    step(1'b0, '0, '0, 1'b1, 1'b0, '0);
    chk("lat_c1", 64'(out_valid), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0);
    chk("lat_c2", 64'(out_valid), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0);
    chk("lat_c3", 64'(out_valid), 64'd1);
    drain();

    // overflow, nan, underflow, signed zero, flushed denormal, rounding
    send(32'h7F000000, 32'hC0000000, 1'b1, {32'hFF800000, 2'b10});
    send(32'h7F800000, 32'h00000000, 1'b1, {32'h7FC00000, 2'b00});
    send(32'h00800000, 32'h3F000000, 1'b1, {32'h00000000, 2'b01});
    send(32'h80000000, 32'h3F800000, 1'b1, {32'h80000000, 2'b00});
    send(32'h00000001, 32'h7F000000, 1'b1, {32'h00000000, 2'b00});
    send(32'h3F800001, 32'h3F800001, 1'b1, {32'h3F800002, 2'b00});
    send(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, {32'h407FFFFE, 2'b00});
    send(32'h3FFFFFFF, 32'h3F800001, 1'b1, {32'h40000000, 2'b00});
    drain();

    // back-pressure: five back-to-back operands, consumer stalled for cycles 2-9
    bp_a = '{32'h7F000000, 32'h3FC00000, 32'h7F000000, 32'h3F800001, 32'h00800000};
    bp_b = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'h3F800001, 32'h3F000000};
    bp_e = '{{32'h7F800000, 2'b10}, {32'h40400000, 2'b00}, {32'hFF800000, 2'b10},
             {32'h3F800002, 2'b00}, {32'h00000000, 2'b01}};
    fed = 0;
    was_stall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      idx = (fed < 5) ? fed : 4;
      step(fed < 5, bp_a[idx], bp_b[idx], !(c >= 2 && c <= 9), 1'b1, bp_e[idx]);
      if (accepted) fed++;
      if (c == 3) begin
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_accepted", 64'(fed), 64'd3);
      end
      if (out_valid && !out_ready) begin
        if (was_stall) chk("bp_y_hold", 64'(y), 64'(y_hold));
        y_hold = y;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (fed == 5 && scb.size() == 0) break;
    end
    chk("bp_fed", 64'(fed), 64'd5);
    chk("bp_drained", 64'(scb.size()), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0);
`ifdef FMUL_EXC_CNT_EN
    chk("ovf_cnt", 64'(ovf_cnt), 64'(exp_ovf_n));
    chk("udf_cnt", 64'(udf_cnt), 64'(exp_udf_n));
`endif

    // randomized traffic with random source/sink stalls
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 7, rnd_op(), rnd_op(), $urandom_range(0, 3) != 0, 1'b0, '0);
    end
    drain();
    step(1'b0, '0, '0, 1'b1, 1'b0, '0);
`ifdef FMUL_EXC_CNT_EN
    chk("rand_ovf_cnt", 64'(ovf_cnt), 64'(exp_ovf_n));
    chk("rand_udf_cnt", 64'(udf_cnt), 64'(exp_udf_n));
`endif

    // reset with three operations in flight
    send(32'h7F000000, 32'h40000000, 1'b1, {32'h7F800000, 2'b10});
    send(32'h3FC00000, 32'h40000000, 1'b1, {32'h40400000, 2'b00});
    send(32'h00800000, 32'h3F000000, 1'b1, {32'h00000000, 2'b01});
    @(negedge clk);
    chk("mid_in_flight", 64'(out_valid), 64'd1);
    #2;
    rstn = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_y", 64'(y), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    chk("mid_rst_udf", 64'(udf), 64'd0);
`ifdef FMUL_EXC_CNT_EN
    chk("mid_rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    chk("mid_rst_udf_cnt", 64'(udf_cnt), 64'd0);
`endif
    scb.delete();
    exp_ovf_n = 0;
    exp_udf_n = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 1'b0, '0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
